// File: rtl/prio_enc_rr.sv
// prio_enc_rr: pending-latched priority encoder, fixed or round-robin grant, registered valid/ready output; PRIO_ENC_DROP_CNT_EN adds a collision counter
module prio_enc_rr #(
  parameter int N = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  input  logic             mode,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_onehot,
  output logic [N-1:0]     pending,
  output logic [7:0]       drop_cnt
);
  logic [N-1:0] pending_q, pending_d, cand, sel_oh, onehot_q, onehot_d;
  logic [IDX_W-1:0] sel, fix_sel, rr_sel, rr_ptr_q, rr_ptr_d, idx_q, idx_d;
  logic valid_q, valid_d, load;
  assign cand = pending_q | req_in;
  always_comb begin
    fix_sel = '0;
    for (int i = 0; i < N; i++) fix_sel = cand[i] ? IDX_W'(i) : fix_sel;
  end
  // later iterations overwrite earlier ones, so the slot just below rr_ptr wins and rr_ptr itself is checked last
  always_comb begin
    rr_sel = '0;
    for (int k = N; k >= 1; k--) begin
      logic [IDX_W-1:0] j;
      j = IDX_W'((int'(rr_ptr_q) + N - k) % N);
      rr_sel = cand[j] ? j : rr_sel;
    end
  end
  assign sel    = mode ? rr_sel : fix_sel;
  assign sel_oh = N'(1) << sel;
  assign load   = (!valid_q || out_ready) && |cand;
  always_comb begin
    pending_d = load ? cand & ~sel_oh : cand;
    valid_d   = load || (valid_q && !out_ready);
    idx_d     = load ? sel : idx_q;
    onehot_d  = load ? sel_oh : (valid_d ? onehot_q : '0);
    rr_ptr_d  = (load && mode) ? sel : rr_ptr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      onehot_q  <= '0;
      rr_ptr_q  <= '0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      onehot_q  <= onehot_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end
  assign out_valid  = valid_q;
  assign out_idx    = idx_q;
  assign out_onehot = onehot_q;
  assign pending    = pending_q;
`ifdef PRIO_ENC_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;
  logic drop_hit;
  assign drop_hit = |(req_in & pending_q & ~(load ? sel_oh : '0));
  assign drop_d   = (drop_hit && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= '0;
    else drop_q <= drop_d;
  end
  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_prio_enc_rr.sv
// tb_prio_enc_rr: scoreboard bench for prio_enc_rr, directed test-plan cases then random traffic
module tb_prio_enc_rr;
  localparam int N = 8;
  logic clk = 0, rst = 1, mode = 0, out_ready = 0;
  logic [N-1:0] req_in = '0;
  logic out_valid;
  logic [2:0] out_idx;
  logic [N-1:0] out_onehot, pending;
  logic [7:0] drop_cnt;
  prio_enc_rr #(.N(N)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .mode(mode), .out_ready(out_ready),
    .out_valid(out_valid), .out_idx(out_idx), .out_onehot(out_onehot),
    .pending(pending), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  int n_checks = 0, n_fail = 0;
  int exp_q[$];
  logic m_valid;
  logic [2:0] m_idx;
  logic [7:0] m_pend;
  int m_ptr, m_drop;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int pick(input logic [7:0] c, input logic md, input int ptr);
    if (!md) begin
      for (int i = N - 1; i >= 0; i--) if (c[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (c[(ptr - k + N) % N]) return (ptr - k + N) % N;
    end
    return -1;
  endfunction
  task automatic model_reset();
    m_valid = 0; m_idx = 0; m_pend = 0; m_ptr = 0; m_drop = 0;
    exp_q.delete();
  endtask
  task automatic model_step();
    logic [7:0] cand, hit;
    logic ld;
    int s;
    cand = m_pend | req_in;
    ld = (!m_valid || out_ready) && cand != 0;
    s = ld ? pick(cand, mode, m_ptr) : 0;
    hit = req_in & m_pend;
    if (ld) hit[s] = 1'b0;
`ifdef PRIO_ENC_DROP_CNT_EN
    if (hit != 0 && m_drop < 255) m_drop++;
`endif
    if (ld) begin
      m_valid = 1; m_idx = 3'(s); m_pend = cand; m_pend[s] = 1'b0;
      exp_q.push_back(s);
      if (mode) m_ptr = s;
    end else begin
      m_pend = cand;
      if (m_valid && out_ready) m_valid = 0;
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (!rst) model_step();
  end
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", out_valid, m_valid);
      chk("pending", pending, m_pend);
      chk("onehot", out_onehot, m_valid ? 8'(1) << m_idx : 8'h00);
      chk("drop_cnt", drop_cnt, m_drop);
      if (out_valid) chk("idx_hold", out_idx, m_idx);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_idx: got %0d expected no grant (queue empty) at %0t", out_idx, $time);
        end else chk("sb_idx", out_idx, exp_q.pop_front());
      end
    end
  end
  task automatic drive(input logic [7:0] r, input logic md, input logic rd);
    @(posedge clk);
    #2;
    req_in = r; mode = md; out_ready = rd;
  endtask
  task automatic do_reset();
    #1 rst = 1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_pending", pending, 0);
    chk("rst_onehot", out_onehot, 0);
    model_reset();
    @(posedge clk);
    #3 rst = 0;
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_valid", out_valid, 0);
    chk("reset_idx", out_idx, 0);
    chk("reset_onehot", out_onehot, 0);
    chk("reset_pending", pending, 0);
    chk("reset_drop", drop_cnt, 0);
    rst = 0;
    drive(8'h24, 0, 1);
    drive(8'h00, 0, 1);
    chk("t1_idx5", out_idx, 5); chk("t1_pend", pending, 8'h04); chk("t1_valid", out_valid, 1);
    drive(8'h00, 0, 1);
    chk("t1_idx2", out_idx, 2); chk("t1_pend0", pending, 0);
    drive(8'h00, 0, 1);
    chk("t1_idle", out_valid, 0);
    drive(8'h81, 0, 0);
    drive(8'h00, 0, 0);
    chk("t2_idx7", out_idx, 7); chk("t2_pend", pending, 8'h01);
    repeat (5) begin
      drive(8'h00, 0, 0);
      chk("t2_hold", out_idx, 7);
    end
    drive(8'h00, 0, 1);
    drive(8'h00, 0, 1);
    chk("t2_idx0", out_idx, 0);
    drive(8'h00, 0, 1);
    drive(8'hFF, 1, 1);
    for (int k = 0; k < 9; k++) begin
      drive(8'hFF, 1, 1);
      chk("t3_rr_idx", out_idx, (15 - k) % 8);
      chk("t3_rr_valid", out_valid, 1);
    end
    repeat (10) drive(8'h00, 1, 1);
    drive(8'h08, 1, 1);
    drive(8'h00, 1, 1);
    chk("t4_idx3", out_idx, 3);
    drive(8'h00, 1, 1);
    drive(8'h18, 1, 1);
    drive(8'h00, 1, 1);
    chk("t4_idx4", out_idx, 4);
    drive(8'h00, 1, 1);
    chk("t4_idx3b", out_idx, 3);
    drive(8'h00, 1, 1);
    drive(8'h10, 0, 0);
    drive(8'h0F, 0, 0);
    drive(8'h00, 0, 0);
    chk("t5_pend", pending, 8'h0F); chk("t5_valid", out_valid, 1);
    do_reset();
    drive(8'h0F, 0, 1);
    drive(8'h00, 0, 1);
    chk("t5_first", out_idx, 3);
    repeat (6) drive(8'h00, 0, 1);
    drive(8'h02, 0, 0);
    repeat (310) drive(8'h02, 0, 0);
`ifdef PRIO_ENC_DROP_CNT_EN
    chk("t6_drop_sat", drop_cnt, 255);
`else
    chk("t6_drop_zero", drop_cnt, 0);
`endif
    repeat (4) drive(8'h00, 0, 1);
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] r;
      logic md;
      r = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      md = ($urandom_range(0, 15) == 0) ? ~mode : mode;
      drive(r, md, $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 399) == 0) do_reset();
    end
    repeat (20) drive(8'h00, mode, 1);
    chk("drain_valid", out_valid, 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/prio_enc_rr.md
Name: prio_enc_rr

Overview:
- Parametrised successor to the group's combinational priority encoder.
- Latches request pulses into a pending register and selects one index per grant, using either fixed highest-index-first priority or round-robin priority.
- Presents the selected index, registered, on a valid/ready output handshake.
- Sits between raw request inputs (ui_in-style pins or internal event strobes) and downstream consumers that take one index at a time.

Parameters:
- N, 8, number of request lines (N >= 2).
- IDX_W, $clog2(N), width of the encoded index; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_in  input  N  request strobes; pulse or level, sampled every cycle.
- mode  input  1  0 = fixed priority (highest index wins); 1 = round-robin.
- out_ready  input  1  consumer accepts out_idx when high with out_valid.
- out_valid  output  1  out_idx/out_onehot hold a granted request.
- out_idx  output  IDX_W  encoded index of the granted request.
- out_onehot  output  N  one-hot form of out_idx; all-zero when out_valid=0.
- pending  output  N  requests captured but not yet granted.
- drop_cnt  output  8  collision counter (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): pending=0, out_valid=0, out_idx=0, out_onehot=0, rr_ptr=0, drop_cnt=0.
- cand = pending | req_in (combinational).
- load = (!out_valid || out_ready) && (cand != 0).
- On load:
  - out_valid<=1.
  - out_idx<=sel, out_onehot<=1<<sel.
  - pending<=cand & ~(1<<sel).
  - In mode=1, rr_ptr<=sel.
- Without load: pending<=cand. If out_valid && out_ready && cand==0, then out_valid<=0 and out_onehot<=0; out_idx holds its last value.
- Latency: req_in high at edge t with the output free gives out_valid=1 after edge t (one cycle).
- Back-to-back: a handshake and a new load in the same cycle keep out_valid=1 with no bubble.
- Fixed select (mode=0): sel = highest set bit of cand.
- Round-robin select (mode=1):
  - Search cand descending from rr_ptr-1, wrapping from 0 to N-1.
  - rr_ptr itself is checked last.
  - With rr_ptr=0 the search starts at N-1, so the first RR grant after reset equals the fixed-priority result.
- Mode switch: takes effect at the next load. rr_ptr is kept while in mode 0 (not updated) and is used again on return to mode 1.
- Holding: while out_valid=1 && out_ready=0, the outputs are frozen; new requests accumulate in pending.
- Same-bit coincidence: a req_in bit equal to sel in a load cycle is consumed by that grant. A level request re-sets pending on the next cycle.
- Re-request of a pending bit before it is granted merges into it (one grant only).
- Mid-operation reset: out_valid drops immediately (async) and all pending requests are lost.
- out_idx must never change while out_valid=1 && out_ready=0.

Optional Feature:
- Macro: PRIO_ENC_DROP_CNT_EN.
- Defined:
  - Each cycle, if any bit satisfies req_in[i] && pending[i] && !(load && sel==i), drop_cnt increments by 1 (one per cycle regardless of how many bits).
  - Saturates at 255.
  - Cleared only by rst.
- Undefined: drop_cnt is tied to 0 and no counter logic is synthesised. The port remains present.

Test Plan (N=8):
- Reset, then req_in=8'b0010_0100 for one cycle, mode=0, out_ready=1 -> next cycle out_valid=1, out_idx=5, pending=8'b0000_0100; following cycle out_idx=2; then out_valid=0, pending=0.
- mode=0, out_ready=0, req_in=8'h81 pulse -> out_idx=7 held stable for 5 cycles, pending=8'h01; raise out_ready -> out_idx=0 next cycle.
- mode=1, req_in held at 8'hFF, out_ready=1 -> out_idx sequence 7,6,5,4,3,2,1,0,7 with out_valid continuously 1.
- mode=1, grant index 3 (rr_ptr=3), then req_in=8'b0001_1000 -> out_idx=4 is granted only after 2,1,0,7,6,5 are checked; confirm out_idx=4 and then 3.
- Assert rst while out_valid=1 with pending=8'h0F -> out_valid=0 and pending=0 immediately; first grant after release with req_in=8'h0F is index 3.
- PRIO_ENC_DROP_CNT_EN defined, out_ready=0, req_in=8'h02 held for 300 cycles -> drop_cnt saturates at 255. Macro undefined -> drop_cnt stays 0.
